mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  M stage of the 6-stage pipeline: consumes the registered EX result (address or ALU value) and store data.
//  Issues loads/stores to data memory via a req/gnt + rvalid handshake and aligns/extends load data.
//  Stalls upstream while an access is in flight; feeds the M/W pipeline register to writeback.
// PARAMETERS
//  XLEN       32  datapath/address width (only 32 supported)
//  REG_AW     5   register index width
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  m_valid     in   1      instruction present in M; m_* held stable while m_stall=1
//  m_mem_rd    in   1      load
//  m_mem_wr    in   1      store (ignored if m_mem_rd=1)
//  m_funct3    in   3      size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  m_addr      in   XLEN   EX result: address for mem ops, writeback value otherwise
//  m_wdata     in   XLEN   store data (rs2)
//  m_rd        in   REG_AW destination register
//  m_reg_we    in   1      register write enable
//  m_stall     out  1      hold M and upstream stages
//  dmem_req    out  1      request; held with fields stable until dmem_gnt
//  dmem_we     out  1      1 = store
//  dmem_addr   out  XLEN   word-aligned address ({addr[31:2],2'b00})
//  dmem_be     out  4      byte enables
//  dmem_wdata  out  XLEN   lane-replicated store data
//  dmem_gnt    in   1      request accepted this cycle
//  dmem_rvalid in   1      load data valid (earliest 1 cycle after gnt)
//  dmem_rdata  in   XLEN   load word
//  w_valid     out  1      registered: instruction retired to W
//  w_rd        out  REG_AW registered destination
//  w_reg_we    out  1      registered write enable
//  w_data      out  XLEN   registered writeback value
//  w_misalign  out  1      registered misalignment exception (MEM_MISALIGN_TRAP_EN only)
// BEHAVIOUR
//  Reset: state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, w_* all 0; m_stall 0.
//  FSM IDLE/REQ/WAIT/RESP. W regs capture at each edge with m_valid & ~m_stall, else w_valid<=0.
//  IDLE: non-mem op -> m_stall=0, W captures m_addr (1-cycle latency). Mem op -> m_stall=1, latch addr/be/wdata/size -> REQ.
//  REQ: dmem_req=1, m_stall=1; gnt & store -> RESP; gnt & load -> WAIT. No gnt: hold all dmem_* stable.
//  WAIT: m_stall=1; on rvalid latch aligned data -> RESP. rvalid in IDLE/REQ/RESP is ignored.
//  RESP: m_stall=0; W captures (load: aligned data; store: w_reg_we=0) -> IDLE.
//  Min latency arrival->w_valid: store 3 cycles, load 4 cycles.
//  Store lanes: B be=4'b0001<<a[1:0], wdata={4{b}}; H be=4'b0011<<{a[1],1'b0}, wdata={2{h}}; W be=4'hF.
//  Load extract: byte at a[1:0], half at a[1]; B/H sign-extend, BU/HU zero-extend, W as-is.
//  funct3 011/110/111 treated as W.
//  rst mid-operation: next edge IDLE, dmem_req drops, W cleared; in-flight response discarded.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: H with a[0]=1 or W with a[1:0]!=0 -> no dmem request, no stall;
//   W captures w_valid=1, w_reg_we=0, w_misalign=1.
//  Not defined: w_misalign port absent; low bits ignored (H uses a[1] only, W uses lane 0), access proceeds.
// STRUCTURE
//  mem_pkg: funct3 size localparams, mem_state_t enum {IDLE,REQ,WAIT,RESP}, be/lane helper functions.
//  Sub-module load_aligner (combinational): rdata, a[1:0], funct3 -> extended XLEN value.
//  FSM, request registers and M/W register in this module.
// TESTING
//  ALU op m_addr=0x1234, m_rd=5, m_reg_we=1 -> next edge w_data=0x1234, w_rd=5; m_stall never 1.
//  SB a=0x1003 wdata=0xAB, gnt after 2 cycles -> dmem_addr=0x1000, be=4'b1000, wdata=0xABABABAB, stable until gnt.
//  LB a=0x2002 rdata=0x0080_0000 -> w_data=0xFFFFFF80; LBU -> 0x80; LH rdata=0x8001_0000 -> 0xFFFF8001.
//  LW a=0x3001: with EN -> no dmem_req, w_misalign=1, w_reg_we=0; without -> dmem_addr=0x3000, be=4'hF.
//  rst in WAIT then rvalid next cycle -> state IDLE, dmem_req=0, w_valid=0, late rdata not written.
//  Load with gnt low 5 cycles then ALU op -> m_stall=1 throughout, fields stable; ALU op retires 1 cycle after load.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: access-size decode, M-stage FSM states and lane helpers shared by
// mem_access_stage and load_aligner. Data-side helpers assume a 32-bit datapath.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} mem_state_t;

  // Unlisted encodings (011/110/111) fall through to word accesses.
  function automatic mem_size_t access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic load_unsigned(input logic [2:0] funct3);
    return (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (access_size(funct3))
      SZ_B:    return 4'b0001 << addr_lo;
      SZ_H:    return 4'b0011 << {addr_lo[1], 1'b0};
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] funct3, input logic [31:0] data);
    case (access_size(funct3))
      SZ_B:    return {4{data[7:0]}};
      SZ_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (access_size(funct3))
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner.sv
// load_aligner: picks the addressed byte/half out of a load word and
// sign- or zero-extends it to XLEN; words pass through unchanged.
module load_aligner
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        ext_sign;

  // Lane select followed by size-dependent extension.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    ext_sign = !load_unsigned(funct3);
    case (access_size(funct3))
      SZ_B:    data = {{(XLEN-8){ext_sign & byte_v[7]}}, byte_v};
      SZ_H:    data = {{(XLEN-16){ext_sign & half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: M stage of the pipeline. Issues data-memory requests over
// a req/gnt + rvalid handshake, stalls upstream while an access is in flight,
// and drives the M/W pipeline register.
// Optional build macro: MEM_MISALIGN_TRAP_EN (misaligned H/W accesses trap
// instead of going to memory; adds the w_misalign port).
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  logic              m_mem_rd,
  input  logic              m_mem_wr,
  input  logic [2:0]        m_funct3,
  input  logic [XLEN-1:0]   m_addr,
  input  logic [XLEN-1:0]   m_wdata,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_reg_we,
  output logic              m_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              w_valid,
  output logic [REG_AW-1:0] w_rd,
  output logic              w_reg_we,
  output logic [XLEN-1:0]   w_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              w_misalign
`endif
);

  mem_state_t      state;
  logic [1:0]      req_lo;
  logic [2:0]      req_f3;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] aligned;
  logic            is_mem;
  logic            misalign;
  logic            start_access;

  load_aligner #(.XLEN(XLEN)) u_load_aligner (
    .rdata   (dmem_rdata),
    .addr_lo (req_lo),
    .funct3  (req_f3),
    .data    (aligned)
  );

  // Decode the instruction in M and derive the upstream stall.
  always_comb begin
    is_mem = m_mem_rd | m_mem_wr;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign = (state == IDLE) & m_valid & is_mem & addr_misaligned(m_funct3, m_addr[1:0]);
`else
    misalign = 1'b0;
`endif
    start_access = (state == IDLE) & m_valid & is_mem & ~misalign;
    m_stall      = start_access | (state == REQ) | (state == WAIT);
  end

  // Access FSM with registered request fields held stable until grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      req_lo     <= '0;
      req_f3     <= '0;
      load_data  <= '0;
    end else begin
      case (state)
        IDLE: if (start_access) begin
          state      <= REQ;
          dmem_req   <= 1'b1;
          dmem_we    <= m_mem_wr & ~m_mem_rd;
          dmem_addr  <= {m_addr[XLEN-1:2], 2'b00};
          dmem_be    <= lane_be(m_funct3, m_addr[1:0]);
          dmem_wdata <= lane_wdata(m_funct3, m_wdata);
          req_lo     <= m_addr[1:0];
          req_f3     <= m_funct3;
        end
        REQ: if (dmem_gnt) begin
          dmem_req <= 1'b0;
          state    <= dmem_we ? RESP : WAIT;
        end
        WAIT: if (dmem_rvalid) begin
          load_data <= aligned;
          state     <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // M/W pipeline register: captures whenever M advances, else bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_valid  <= 1'b0;
      w_rd     <= '0;
      w_reg_we <= 1'b0;
      w_data   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      w_misalign <= 1'b0;
`endif
    end else if (m_valid && !m_stall) begin
      w_valid <= 1'b1;
      w_rd    <= m_rd;
      if (state == RESP) begin
        w_reg_we <= m_reg_we & ~dmem_we;
        w_data   <= dmem_we ? m_addr : load_data;
      end else begin
        w_reg_we <= m_reg_we & ~misalign;
        w_data   <= m_addr;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      w_misalign <= misalign;
`endif
    end else begin
      w_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      w_misalign <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized and directed checks of the M stage against
// a byte-arithmetic reference model and a memory responder with random delays.
module tb_mem_access_stage;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, m_mem_rd, m_mem_wr, m_reg_we;
  logic [2:0]  m_funct3;
  logic [31:0] m_addr, m_wdata;
  logic [4:0]  m_rd;
  logic        m_stall;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        w_valid, w_reg_we;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        w_misalign;
`endif

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_mem_rd(m_mem_rd), .m_mem_wr(m_mem_wr),
    .m_funct3(m_funct3), .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_reg_we(m_reg_we),
    .m_stall(m_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .w_valid(w_valid), .w_rd(w_rd), .w_reg_we(w_reg_we), .w_data(w_data)
`ifdef MEM_MISALIGN_TRAP_EN
    , .w_misalign(w_misalign)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int exp_size(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic int exp_off(input logic [2:0] f3, input logic [31:0] a);
    int n = exp_size(f3);
    if (n == 1) return int'(a[1:0]);
    if (n == 2) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m;
    m = 4'((1 << exp_size(f3)) - 1);
    return m << exp_off(f3, a);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n = exp_size(f3);
    if (n == 1) return 32'(d[7:0]) * 32'h0101_0101;
    if (n == 2) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n = exp_size(f3);
    logic [31:0] mask, v;
    if (n == 4) return d;
    mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (d >> (8 * exp_off(f3, a))) & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic exp_mis(input logic [2:0] f3, input logic [31:0] a);
    int n = exp_size(f3);
    return TRAP && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00));
  endfunction

  // ---------------- driver / memory responder ----------------
  // Presents one instruction, plays the memory side, returns what was observed.
  task automatic do_op(
    input bit rd_op, input bit wr_op, input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] wdat, input logic [31:0] rdat, input logic [4:0] rd_idx, input logic we_in,
    input int gnt_dly, input int rv_dly, input bit chain_alu, input logic [31:0] chain_val,
    output int lat, output int stall_cyc, output int req_cyc, output bit fields_stable, output bit stall_ok,
    output logic [31:0] o_addr, output logic [31:0] o_wdata, output logic [3:0] o_be, output logic o_we,
    output logic [31:0] o_wd, output logic [4:0] o_rd, output logic o_rwe, output logic o_mis);
    int since;
    bit granted_load, gnt_now, consumed, cleared;
    @(posedge clk); #1;
    m_valid = 1'b1; m_mem_rd = rd_op; m_mem_wr = wr_op; m_funct3 = f3;
    m_addr = addr; m_wdata = wdat; m_rd = rd_idx; m_reg_we = we_in;
    lat = -1; stall_cyc = 0; req_cyc = 0; fields_stable = 1'b1; stall_ok = 1'b1;
    o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
    o_wd = '0; o_rd = '0; o_rwe = 1'b0; o_mis = 1'b0;
    since = 0; granted_load = 1'b0; gnt_now = 1'b0; consumed = 1'b0; cleared = 1'b0;
    for (int cyc = 0; cyc < 300 && lat < 0; cyc++) begin
      @(negedge clk);
      if (gnt_now) begin granted_load = !o_we; since = 0; end
      gnt_now = 1'b0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      if (w_valid) begin
        lat = cyc; o_wd = w_data; o_rd = w_rd; o_rwe = w_reg_we;
`ifdef MEM_MISALIGN_TRAP_EN
        o_mis = w_misalign;
`endif
      end else begin
        if (dmem_req) begin
          if (req_cyc == 0) begin
            o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_be; o_we = dmem_we;
          end else if (dmem_addr !== o_addr || dmem_wdata !== o_wdata || dmem_be !== o_be || dmem_we !== o_we)
            fields_stable = 1'b0;
          if (!m_stall) stall_ok = 1'b0;
          if (req_cyc == gnt_dly) begin dmem_gnt = 1'b1; gnt_now = 1'b1; end
          req_cyc++;
        end
        if (granted_load) begin
          if (since == rv_dly) begin dmem_rvalid = 1'b1; dmem_rdata = rdat; granted_load = 1'b0; end
          since++;
        end
        if (!consumed) begin
          if (m_stall) stall_cyc++;
          else consumed = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (consumed && !cleared) begin
        cleared = 1'b1;
        if (chain_alu) begin
          m_mem_rd = 1'b0; m_mem_wr = 1'b0; m_addr = chain_val; m_rd = rd_idx + 5'd1; m_reg_we = 1'b1;
        end else m_valid = 1'b0;
      end
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; m_valid = 0; m_mem_rd = 0; m_mem_wr = 0; m_funct3 = 0; m_addr = 0;
    m_wdata = 0; m_rd = 0; m_reg_we = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({dmem_req, dmem_we, dmem_be} !== 6'd0)
      begin bad++; $display("FAIL reset_dmem_ctl got=%b exp=0", {dmem_req, dmem_we, dmem_be}); end
    total++; if ({dmem_addr, dmem_wdata} !== 64'd0)
      begin bad++; $display("FAIL reset_dmem_data got=%h exp=0", {dmem_addr, dmem_wdata}); end
    total++; if ({w_valid, w_rd, w_reg_we, w_data} !== 39'd0)
      begin bad++; $display("FAIL reset_w got=%h exp=0", {w_valid, w_rd, w_reg_we, w_data}); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if (m_stall !== 1'b0 || w_valid !== 1'b0)
      begin bad++; $display("FAIL reset_idle stall=%b wv=%b exp=0,0", m_stall, w_valid); end
  endtask

  task automatic test_alu();
    int lat, stc, rqc; bit stab, sok;
    logic [31:0] oa, ow, wd, v; logic [3:0] obe; logic owe, wwe, wm, we; logic [4:0] wr, rdx;
    do_op(0, 0, 3'b010, 32'h1234, 0, 0, 5'd5, 1, 0, 0, 0, 0,
          lat, stc, rqc, stab, sok, oa, ow, obe, owe, wd, wr, wwe, wm);
    total++; if (wd !== 32'h1234 || wr !== 5'd5 || wwe !== 1'b1)
      begin bad++; $display("FAIL alu_fixed got=%h/%0d/%b exp=1234/5/1", wd, wr, wwe); end
    total++; if (lat !== 1 || stc !== 0 || rqc !== 0)
      begin bad++; $display("FAIL alu_fixed_timing lat=%0d stall=%0d req=%0d exp=1/0/0", lat, stc, rqc); end
    for (int i = 0; i < 4; i++) begin
      v = $urandom; rdx = 5'($urandom); we = 1'($urandom);
      do_op(0, 0, 3'($urandom), v, 0, 0, rdx, we, 0, 0, 0, 0,
            lat, stc, rqc, stab, sok, oa, ow, obe, owe, wd, wr, wwe, wm);
      total++; if (wd !== v || wr !== rdx || wwe !== we || lat !== 1 || stc !== 0)
        begin bad++; $display("FAIL alu_rand got=%h/%0d/%b lat=%0d exp=%h/%0d/%b lat=1", wd, wr, wwe, lat, v, rdx, we); end
    end
  endtask

  task automatic test_store();
    int lat, stc, rqc, g; bit stab, sok;
    logic [31:0] oa, ow, wd, a, d; logic [3:0] obe; logic owe, wwe, wm, mis; logic [4:0] wr;
    logic [2:0] f3;
    do_op(0, 1, 3'b000, 32'h1003, 32'h0000_00AB, 0, 5'd4, 1, 2, 0, 0, 0,
          lat, stc, rqc, stab, sok, oa, ow, obe, owe, wd, wr, wwe, wm);
    total++; if (oa !== 32'h1000 || obe !== 4'b1000 || ow !== 32'hABABABAB || owe !== 1'b1)
      begin bad++; $display("FAIL sb_fields got=%h/%b/%h/%b exp=1000/1000/abababab/1", oa, obe, ow, owe); end
    total++; if (!stab || !sok || rqc !== 3 || lat !== 5 || wwe !== 1'b0)
      begin bad++; $display("FAIL sb_handshake stab=%b sok=%b req=%0d lat=%0d we=%b exp=1/1/3/5/0", stab, sok, rqc, lat, wwe); end
    for (int i = 0; i < 8; i++) begin
      f3 = 3'($urandom_range(0, 2)); a = $urandom; d = $urandom; g = $urandom_range(0, 3);
      mis = exp_mis(f3, a);
      do_op(0, 1, f3, a, d, 0, 5'($urandom), 1, g, 0, 0, 0,
            lat, stc, rqc, stab, sok, oa, ow, obe, owe, wd, wr, wwe, wm);
      if (mis) begin
        total++; if (rqc !== 0 || lat !== 1 || wwe !== 1'b0 || wm !== 1'b1)
          begin bad++; $display("FAIL st_misalign req=%0d lat=%0d we=%b mis=%b exp=0/1/0/1", rqc, lat, wwe, wm); end
      end else begin
        total++; if (oa !== {a[31:2], 2'b00} || obe !== exp_be(f3, a) || ow !== exp_wdata(f3, d))
          begin bad++; $display("FAIL st_fields f3=%0d a=%h got=%h/%b/%h exp=%h/%b/%h", f3, a, oa, obe, ow,
                                {a[31:2], 2'b00}, exp_be(f3, a), exp_wdata(f3, d)); end
        total++; if (!stab || !sok || rqc !== g + 1 || lat !== 3 + g || wwe !== 1'b0)
          begin bad++; $display("FAIL st_timing stab=%b sok=%b req=%0d lat=%0d we=%b exp=1/1/%0d/%0d/0", stab, sok, rqc, lat, wwe, g + 1, 3 + g); end
      end
    end
  endtask

  task automatic test_load();
    int lat, stc, rqc, g, rv; bit stab, sok;
    logic [31:0] oa, ow, wd, a, d; logic [3:0] obe; logic owe, wwe, wm, mis, we; logic [4:0] wr, rdx;
    logic [2:0] f3;
    do_op(1, 0, 3'b000, 32'h2002, 0, 32'h0080_0000, 5'd1, 1, 0, 0, 0, 0,
          lat, stc, rqc, stab, sok, oa, ow, obe, owe, wd, wr, wwe, wm);
    total++; if (wd !== 32'hFFFF_FF80 || lat !== 4)
      begin bad++; $display("FAIL lb got=%h lat=%0d exp=ffffff80 lat=4", wd, lat); end
    do_op(1, 0, 3'b100, 32'h2002, 0, 32'h0080_0000, 5'd1, 1, 1, 1, 0, 0,
          lat, stc, rqc, stab, sok, oa, ow, obe, owe, wd, wr, wwe, wm);
    total++; if (wd !== 32'h0000_0080)
      begin bad++; $display("FAIL lbu got=%h exp=00000080", wd); end
    do_op(1, 0, 3'b001, 32'h2002, 0, 32'h8001_0000, 5'd1, 1, 0, 2, 0, 0,
          lat, stc, rqc, stab, sok, oa, ow, obe, owe, wd, wr, wwe, wm);
    total++; if (wd !== 32'hFFFF_8001 || obe !== 4'b1100)
      begin bad++; $display("FAIL lh got=%h be=%b exp=ffff8001 be=1100", wd, obe); end
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7)); a = $urandom; d = $urandom;
      g = $urandom_range(0, 3); rv = $urandom_range(0, 3); rdx = 5'($urandom); we = 1'($urandom);
      mis = exp_mis(f3, a);
      do_op(1, 0, f3, a, 0, d, rdx, we, g, rv, 0, 0,
            lat, stc, rqc, stab, sok, oa, ow, obe, owe, wd, wr, wwe, wm);
      total++; if (wr !== rdx)
        begin bad++; $display("FAIL ld_rd got=%0d exp=%0d", wr, rdx); end
      if (mis) begin
        total++; if (rqc !== 0 || lat !== 1 || wwe !== 1'b0 || wm !== 1'b1)
          begin bad++; $display("FAIL ld_misalign req=%0d lat=%0d we=%b mis=%b exp=0/1/0/1", rqc, lat, wwe, wm); end
      end else begin
        total++; if (wd !== exp_load(f3, a, d))
          begin bad++; $display("FAIL ld_data f3=%0d a=%h rdata=%h got=%h exp=%h", f3, a, d, wd, exp_load(f3, a, d)); end
        total++; if (oa !== {a[31:2], 2'b00} || obe !== exp_be(f3, a) || owe !== 1'b0)
          begin bad++; $display("FAIL ld_fields got=%h/%b/%b exp=%h/%b/0", oa, obe, owe, {a[31:2], 2'b00}, exp_be(f3, a)); end
        total++; if (!stab || !sok || lat !== 4 + g + rv || wwe !== we)
          begin bad++; $display("FAIL ld_timing stab=%b sok=%b lat=%0d we=%b exp=1/1/%0d/%b", stab, sok, lat, wwe, 4 + g + rv, we); end
      end
    end
  endtask

  task automatic test_misalign();
    int lat, stc, rqc; bit stab, sok;
    logic [31:0] oa, ow, wd; logic [3:0] obe; logic owe, wwe, wm; logic [4:0] wr;
    do_op(1, 0, 3'b010, 32'h3001, 0, 32'h1122_3344, 5'd3, 1, 0, 0, 0, 0,
          lat, stc, rqc, stab, sok, oa, ow, obe, owe, wd, wr, wwe, wm);
`ifdef MEM_MISALIGN_TRAP_EN
    total++; if (rqc !== 0 || lat !== 1 || stc !== 0)
      begin bad++; $display("FAIL lw_trap_noreq req=%0d lat=%0d stall=%0d exp=0/1/0", rqc, lat, stc); end
    total++; if (wm !== 1'b1 || wwe !== 1'b0)
      begin bad++; $display("FAIL lw_trap_flags mis=%b we=%b exp=1/0", wm, wwe); end
`else
    total++; if (oa !== 32'h3000 || obe !== 4'hF)
      begin bad++; $display("FAIL lw_unaligned_req got=%h/%b exp=3000/1111", oa, obe); end
    total++; if (wd !== 32'h1122_3344 || wwe !== 1'b1)
      begin bad++; $display("FAIL lw_unaligned_data got=%h/%b exp=11223344/1", wd, wwe); end
`endif
  endtask

  task automatic test_back_to_back();
    int lat, stc, rqc; bit stab, sok;
    logic [31:0] oa, ow, wd; logic [3:0] obe; logic owe, wwe, wm; logic [4:0] wr;
    do_op(1, 0, 3'b010, 32'h5000, 0, 32'h0BAD_F00D, 5'd6, 1, 5, 1, 1, 32'hCAFE_0001,
          lat, stc, rqc, stab, sok, oa, ow, obe, owe, wd, wr, wwe, wm);
    total++; if (!stab || !sok || rqc !== 6 || stc !== 9)
      begin bad++; $display("FAIL b2b_stall stab=%b sok=%b req=%0d stall=%0d exp=1/1/6/9", stab, sok, rqc, stc); end
    total++; if (wd !== 32'h0BAD_F00D || wr !== 5'd6 || lat !== 10)
      begin bad++; $display("FAIL b2b_load got=%h/%0d lat=%0d exp=0badf00d/6 lat=10", wd, wr, lat); end
    @(negedge clk);
    total++; if (w_valid !== 1'b1 || w_data !== 32'hCAFE_0001 || w_rd !== 5'd7)
      begin bad++; $display("FAIL b2b_alu got=%b/%h/%0d exp=1/cafe0001/7", w_valid, w_data, w_rd); end
    m_valid = 1'b0;
  endtask

  task automatic test_reset_midop();
    bit seen = 1'b0;
    @(posedge clk); #1;
    m_valid = 1; m_mem_rd = 1; m_mem_wr = 0; m_funct3 = 3'b010; m_addr = 32'h4000; m_rd = 5'd9; m_reg_we = 1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (dmem_req) begin seen = 1'b1; dmem_gnt = 1'b1; end
    end
    total++; if (!seen)
      begin bad++; $display("FAIL rst_mid_req got=no_req exp=req"); end
    @(negedge clk); dmem_gnt = 1'b0;
    total++; if (m_stall !== 1'b1 || dmem_req !== 1'b0)
      begin bad++; $display("FAIL rst_mid_wait stall=%b req=%b exp=1/0", m_stall, dmem_req); end
    rst = 1'b1; m_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    total++; if (dmem_req !== 1'b0 || w_valid !== 1'b0 || m_stall !== 1'b0 || w_data !== 32'd0)
      begin bad++; $display("FAIL rst_mid_after req=%b wv=%b stall=%b wd=%h exp=0/0/0/0", dmem_req, w_valid, m_stall, w_data); end
    @(negedge clk); dmem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++; if (w_valid !== 1'b0 || w_data !== 32'd0 || dmem_req !== 1'b0 || m_stall !== 1'b0)
        begin bad++; $display("FAIL rst_mid_late wv=%b wd=%h req=%b stall=%b exp=0/0/0/0", w_valid, w_data, dmem_req, m_stall); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_misalign();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
